// File: rtl/readback_scheduler_pkg.sv
// Shared definitions for the readback scheduler: config sub-addresses and
// the selection FSM encoding.
package readback_scheduler_pkg;

    // Config sub-addresses decoded from in_ctrl on an in_wr strobe.
    localparam logic [3:0] RBS_CFG_URG = 4'd0;  // urgent mask
    localparam logic [3:0] RBS_CFG_AGE = 4'd1;  // promotion threshold
    localparam logic [3:0] RBS_CFG_OVF = 4'd2;  // overflow write-1-to-clear

    // IDLE: nothing on the output. PRESENT: one word held until accepted.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/readback_scheduler_rr.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping past the top back to bit 0.
module rr_pick #(
    parameter int N  = 6,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          found
);

    logic [PW-1:0] cand;

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise paths that find nothing would infer latches.
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = PW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/readback_scheduler.sv
// Shares the core->Jetson readback path between N_CH producers. Each channel
// has a one-entry slot; slots are served urgent-class first, round-robin
// within each class, with age-based promotion of waiting normal slots.
module readback_scheduler
    import readback_scheduler_pkg::*;
#(
    parameter int                N_CH    = 6,
    parameter int                DW      = 28,
    parameter int                AGE_W   = 16,
    parameter logic [AGE_W-1:0]  AGE_DEF = 16'd50000,
    parameter logic [N_CH-1:0]   URG_DEF = 6'b000010
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [23:0]          in_data,
    input  logic                 in_wr,
    input  logic [3:0]           in_ctrl,
    input  logic [N_CH*DW-1:0]   req_data,
    input  logic [N_CH-1:0]      req_wr,
    output logic [N_CH-1:0]      req_busy,
    output logic [DW-1:0]        out_data,
    output logic [3:0]           out_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 urgent,
    output logic [N_CH-1:0]      ovf
);

    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t            state, state_next;
    logic [N_CH-1:0]   slot_full;
    logic [DW-1:0]     slot_data [N_CH];
    logic [AGE_W-1:0]  age       [N_CH];
    logic [N_CH-1:0]   urg_mask;
    logic [AGE_W-1:0]  age_thr;
    logic [PW-1:0]     rr_urg, rr_norm, sel_idx, ptr_next;
    logic              sel_urg;

    logic [N_CH-1:0]   eff_urg, pres_mask, ack_mask, urg_cand, norm_cand;
    logic [N_CH-1:0]   ovf_clr, ovf_set;
    logic [PW-1:0]     urg_idx, norm_idx, pick_idx;
    logic              urg_found, norm_found, load, ack;
    logic              cfg_unused;

    assign cfg_unused = ^in_data;
    assign req_busy   = slot_full;
    assign out_valid  = (state == ST_PRESENT);
    assign ack        = out_valid && out_ready;
    assign pres_mask  = out_valid ? (N_CH'(1) << sel_idx) : '0;
    assign ack_mask   = ack ? pres_mask : '0;
    assign urg_cand   = slot_full & eff_urg & ~pres_mask;
    assign norm_cand  = slot_full & ~eff_urg & ~pres_mask;
    assign pick_idx   = urg_found ? urg_idx : norm_idx;
    assign ptr_next   = (sel_idx == PW'(N_CH - 1)) ? '0 : sel_idx + PW'(1);
    assign ovf_set    = req_wr & slot_full;
    assign ovf_clr    = (in_wr && in_ctrl == RBS_CFG_OVF) ? in_data[N_CH-1:0] : '0;

    // Effective urgency: static mask or promoted by waiting too long.
    always_comb begin
        eff_urg = '0;
        for (int i = 0; i < N_CH; i++)
            eff_urg[i] = urg_mask[i] | ((age_thr != '0) && (age[i] >= age_thr));
    end

    rr_pick #(.N(N_CH), .PW(PW)) u_pick_urg (
        .req(urg_cand), .ptr(rr_urg), .idx(urg_idx), .found(urg_found)
    );

    rr_pick #(.N(N_CH), .PW(PW)) u_pick_norm (
        .req(norm_cand), .ptr(rr_norm), .idx(norm_idx), .found(norm_found)
    );

    // Next-state logic: select from IDLE, hold in PRESENT until accepted.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (urg_found || norm_found) begin
                    state_next = ST_PRESENT;
                    load       = 1'b1;
                end
            end
            ST_PRESENT: if (out_ready) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // State register, presented word and per-class round-robin pointers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= ST_IDLE;
            sel_idx  <= '0;
            sel_urg  <= 1'b0;
            out_data <= '0;
            out_addr <= '0;
            rr_urg   <= '0;
            rr_norm  <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                sel_idx  <= pick_idx;
                sel_urg  <= urg_found;
                out_data <= slot_data[pick_idx];
                out_addr <= 4'(pick_idx);
            end
            if (ack) begin
                if (sel_urg) rr_urg  <= ptr_next;
                else         rr_norm <= ptr_next;
            end
        end
    end

    // Slot occupancy, wait counters and sticky overflow flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full <= '0;
            ovf       <= '0;
            for (int i = 0; i < N_CH; i++) age[i] <= '0;
        end else begin
            ovf <= (ovf & ~ovf_clr) | ovf_set;
            for (int i = 0; i < N_CH; i++) begin
                if (ack_mask[i])
                    slot_full[i] <= 1'b0;
                else if (req_wr[i] && !slot_full[i])
                    slot_full[i] <= 1'b1;

                if (!slot_full[i] || ack_mask[i])
                    age[i] <= '0;
                else if (!pres_mask[i] && age[i] != '1)
                    age[i] <= age[i] + AGE_W'(1);
            end
        end
    end

    // Slot payload capture into empty slots only.
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset; slot_full alone says whether an entry is meaningful.
        for (int i = 0; i < N_CH; i++)
            if (req_wr[i] && !slot_full[i])
                slot_data[i] <= req_data[i*DW +: DW];
    end

    // Configuration registers written over the Jetson bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            urg_mask <= URG_DEF;
            age_thr  <= AGE_DEF;
        end else if (in_wr) begin
            case (in_ctrl)
                RBS_CFG_URG: urg_mask <= in_data[N_CH-1:0];
                RBS_CFG_AGE: age_thr  <= in_data[AGE_W-1:0];
                default:     ;
            endcase
        end
    end

    // Urgent hint: pending urgent slots or an urgent word on the output.
    always_ff @(posedge clk) begin
        if (rst) urgent <= 1'b0;
        else     urgent <= (|urg_cand) | (out_valid && sel_urg);
    end

endmodule
